// File: rtl/tcp_pkg.sv
// Shared TCP RX types and constants.
//  FOUR_TUPLE_STRUCT_W : width of a packed four-tuple (flow tag)
//  FLOW_TABLE_STAT_W   : width of the optional flow-table statistics counters
//  four_tuple_struct   : {src_ip, dst_ip, src_port, dst_port}
//  flow_table_state_e  : tcp_flow_table control states
package tcp_pkg;

  localparam int unsigned FOUR_TUPLE_STRUCT_W = 96;
  localparam int unsigned FLOW_TABLE_STAT_W   = 32;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } four_tuple_struct;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StLookupResp,
    StAllocResp
  } flow_table_state_e;

endpackage

// File: rtl/tcp_flow_free_list.sv
// FIFO of free flowids.
//  clk, rst      : clock, asynchronous active-high reset (list empty after reset)
//  push, push_id : enqueue an id (ignored when full)
//  pop           : dequeue the head (ignored when empty)
//  pop_id        : current head of the list
//  empty, full   : occupancy flags
module tcp_flow_free_list #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned ID_W  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] pop_id,
  output logic            empty,
  output logic            full
);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ID_W:0]   cnt_q;
  logic            push_en, pop_en;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (ID_W + 1)'(DEPTH));
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign pop_id  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_en && !pop_en) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push_en && pop_en) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: only slots written since reset are ever read.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/tcp_flow_table.sv
// Four-tuple -> flowid table for the TCP RX path: CAM lookup, flowid allocation, flowid free.
// Owns its free list so flowids are recycled on teardown (FIFO reissue order).
//  clk, rst                          : clock, asynchronous active-high reset
//  lookup_req_* / lookup_resp_*      : tag lookup, response held until lookup_resp_rdy
//  alloc_req_*  / alloc_resp_*       : install tag; ok (new id), dup (existing id) or full (id 0)
//  free_req_*                        : release a flowid; frees of invalid ids are ignored
//  init_done                         : free list filled, table operational
//  flow_cnt                          : number of valid entries
// Optional macro TCP_FLOW_TABLE_STATS_EN adds saturating counters
//  stat_lookup_miss_cnt, stat_alloc_fail_cnt, stat_bad_free_cnt.
// One request is accepted per cycle, in IDLE only, priority free > alloc > lookup.
module tcp_flow_table
  import tcp_pkg::*;
#(
  parameter int unsigned MAX_FLOWS = 64,
  parameter int unsigned FLOWID_W  = $clog2(MAX_FLOWS),
  parameter int unsigned TAG_W     = FOUR_TUPLE_STRUCT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_req_val,
  input  logic [TAG_W-1:0]             lookup_req_tag,
  output logic                         lookup_req_rdy,
  output logic                         lookup_resp_val,
  output logic                         lookup_resp_hit,
  output logic [FLOWID_W-1:0]          lookup_resp_flowid,
  input  logic                         lookup_resp_rdy,
  input  logic                         alloc_req_val,
  input  logic [TAG_W-1:0]             alloc_req_tag,
  output logic                         alloc_req_rdy,
  output logic                         alloc_resp_val,
  output logic                         alloc_resp_ok,
  output logic                         alloc_resp_dup,
  output logic [FLOWID_W-1:0]          alloc_resp_flowid,
  input  logic                         alloc_resp_rdy,
  input  logic                         free_req_val,
  input  logic [FLOWID_W-1:0]          free_req_flowid,
  output logic                         free_req_rdy,
`ifdef TCP_FLOW_TABLE_STATS_EN
  output logic [FLOW_TABLE_STAT_W-1:0] stat_lookup_miss_cnt,
  output logic [FLOW_TABLE_STAT_W-1:0] stat_alloc_fail_cnt,
  output logic [FLOW_TABLE_STAT_W-1:0] stat_bad_free_cnt,
`endif
  output logic                         init_done,
  output logic [FLOWID_W:0]            flow_cnt
);

  flow_table_state_e state_q, state_d;

  logic [TAG_W-1:0]     tag_q [MAX_FLOWS];
  logic [MAX_FLOWS-1:0] valid_q;
  logic [FLOWID_W-1:0]  init_cnt_q;
  logic [FLOWID_W:0]    flow_cnt_q;

  logic                lookup_val_q, lookup_hit_q;
  logic [FLOWID_W-1:0] lookup_id_q;
  logic                alloc_val_q, alloc_ok_q, alloc_dup_q;
  logic [FLOWID_W-1:0] alloc_id_q;

  logic                idle;
  logic [TAG_W-1:0]    cmp_tag;
  logic [MAX_FLOWS-1:0] match;
  logic                cmp_hit;
  logic [FLOWID_W-1:0] hit_id;
  logic                free_ok, alloc_ok;

  logic                fl_push, fl_pop, fl_empty, fl_full;
  logic [FLOWID_W-1:0] fl_push_id, fl_pop_id;

  // Request arbitration.
  assign idle           = (state_q == StIdle);
  assign free_req_rdy   = idle && free_req_val;
  assign alloc_req_rdy  = idle && alloc_req_val && !free_req_val;
  assign lookup_req_rdy = idle && lookup_req_val && !free_req_val && !alloc_req_val;

  // Single comparator bank shared by alloc and lookup; only one is accepted per cycle.
  assign cmp_tag = alloc_req_rdy ? alloc_req_tag : lookup_req_tag;

  always_comb begin
    for (int unsigned i = 0; i < MAX_FLOWS; i++) begin
      match[i] = valid_q[i] && (tag_q[i] == cmp_tag);
    end
  end

  assign cmp_hit = |match;

  // OR-encode: alloc guarantees at most one match.
  always_comb begin
    hit_id = '0;
    for (int unsigned i = 0; i < MAX_FLOWS; i++) begin
      if (match[i]) hit_id = hit_id | FLOWID_W'(i);
    end
  end

  assign free_ok  = free_req_rdy && valid_q[free_req_flowid];
  assign alloc_ok = alloc_req_rdy && !cmp_hit && !fl_empty;

  assign fl_push    = (state_q == StInit) || free_ok;
  assign fl_push_id = (state_q == StInit) ? init_cnt_q : free_req_flowid;
  assign fl_pop     = alloc_ok;

  tcp_flow_free_list #(
    .DEPTH (MAX_FLOWS),
    .ID_W  (FLOWID_W)
  ) u_free_list (
    .clk     (clk),
    .rst     (rst),
    .push    (fl_push && !fl_full),
    .push_id (fl_push_id),
    .pop     (fl_pop),
    .pop_id  (fl_pop_id),
    .empty   (fl_empty),
    .full    (fl_full)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit: begin
        if (init_cnt_q == FLOWID_W'(MAX_FLOWS - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (alloc_req_rdy) begin
          state_d = StAllocResp;
        end else if (lookup_req_rdy) begin
          state_d = StLookupResp;
        end
      end
      StLookupResp: begin
        if (lookup_resp_rdy) state_d = StIdle;
      end
      StAllocResp: begin
        if (alloc_resp_rdy) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StInit;
      init_cnt_q   <= '0;
      valid_q      <= '0;
      flow_cnt_q   <= '0;
      lookup_val_q <= 1'b0;
      lookup_hit_q <= 1'b0;
      lookup_id_q  <= '0;
      alloc_val_q  <= 1'b0;
      alloc_ok_q   <= 1'b0;
      alloc_dup_q  <= 1'b0;
      alloc_id_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StInit) init_cnt_q <= init_cnt_q + 1'b1;

      if (alloc_ok) begin
        valid_q[fl_pop_id] <= 1'b1;
        flow_cnt_q         <= flow_cnt_q + 1'b1;
      end else if (free_ok) begin
        valid_q[free_req_flowid] <= 1'b0;
        flow_cnt_q               <= flow_cnt_q - 1'b1;
      end

      if (lookup_req_rdy) begin
        lookup_val_q <= 1'b1;
        lookup_hit_q <= cmp_hit;
        lookup_id_q  <= hit_id;
      end else if (lookup_val_q && lookup_resp_rdy) begin
        lookup_val_q <= 1'b0;
      end

      if (alloc_req_rdy) begin
        alloc_val_q <= 1'b1;
        alloc_ok_q  <= alloc_ok;
        alloc_dup_q <= cmp_hit;
        alloc_id_q  <= cmp_hit ? hit_id : (fl_empty ? '0 : fl_pop_id);
      end else if (alloc_val_q && alloc_resp_rdy) begin
        alloc_val_q <= 1'b0;
      end
    end
  end

  // Tag storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_ok) tag_q[fl_pop_id] <= alloc_req_tag;
  end

`ifdef TCP_FLOW_TABLE_STATS_EN
  logic [FLOW_TABLE_STAT_W-1:0] miss_cnt_q, fail_cnt_q, bad_free_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q     <= '0;
      fail_cnt_q     <= '0;
      bad_free_cnt_q <= '0;
    end else begin
      if (lookup_req_rdy && !cmp_hit && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
      if (alloc_req_rdy && !alloc_ok && (fail_cnt_q != '1)) begin
        fail_cnt_q <= fail_cnt_q + 1'b1;
      end
      if (free_req_rdy && !free_ok && (bad_free_cnt_q != '1)) begin
        bad_free_cnt_q <= bad_free_cnt_q + 1'b1;
      end
    end
  end

  assign stat_lookup_miss_cnt = miss_cnt_q;
  assign stat_alloc_fail_cnt  = fail_cnt_q;
  assign stat_bad_free_cnt    = bad_free_cnt_q;
`endif

  assign lookup_resp_val    = lookup_val_q;
  assign lookup_resp_hit    = lookup_hit_q;
  assign lookup_resp_flowid = lookup_id_q;
  assign alloc_resp_val     = alloc_val_q;
  assign alloc_resp_ok      = alloc_ok_q;
  assign alloc_resp_dup     = alloc_dup_q;
  assign alloc_resp_flowid  = alloc_id_q;
  assign init_done          = (state_q != StInit);
  assign flow_cnt           = flow_cnt_q;

endmodule

// File: tb/tb_tcp_flow_table.sv
// Self-checking bench for tcp_flow_table (MAX_FLOWS=4) against a queue-based reference model.
module tb_tcp_flow_table;

  localparam int unsigned MF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lookup_req_val = 1'b0;
  logic [95:0] lookup_req_tag = '0;
  logic        lookup_req_rdy;
  logic        lookup_resp_val, lookup_resp_hit;
  logic [1:0]  lookup_resp_flowid;
  logic        lookup_resp_rdy = 1'b1;
  logic        alloc_req_val = 1'b0;
  logic [95:0] alloc_req_tag = '0;
  logic        alloc_req_rdy;
  logic        alloc_resp_val, alloc_resp_ok, alloc_resp_dup;
  logic [1:0]  alloc_resp_flowid;
  logic        alloc_resp_rdy = 1'b1;
  logic        free_req_val = 1'b0;
  logic [1:0]  free_req_flowid = '0;
  logic        free_req_rdy;
  logic        init_done;
  logic [2:0]  flow_cnt;
`ifdef TCP_FLOW_TABLE_STATS_EN
  logic [31:0] stat_lookup_miss_cnt, stat_alloc_fail_cnt, stat_bad_free_cnt;
`endif

  always #5 clk = ~clk;

  tcp_flow_table #(
    .MAX_FLOWS (MF)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .lookup_req_val     (lookup_req_val),
    .lookup_req_tag     (lookup_req_tag),
    .lookup_req_rdy     (lookup_req_rdy),
    .lookup_resp_val    (lookup_resp_val),
    .lookup_resp_hit    (lookup_resp_hit),
    .lookup_resp_flowid (lookup_resp_flowid),
    .lookup_resp_rdy    (lookup_resp_rdy),
    .alloc_req_val      (alloc_req_val),
    .alloc_req_tag      (alloc_req_tag),
    .alloc_req_rdy      (alloc_req_rdy),
    .alloc_resp_val     (alloc_resp_val),
    .alloc_resp_ok      (alloc_resp_ok),
    .alloc_resp_dup     (alloc_resp_dup),
    .alloc_resp_flowid  (alloc_resp_flowid),
    .alloc_resp_rdy     (alloc_resp_rdy),
    .free_req_val       (free_req_val),
    .free_req_flowid    (free_req_flowid),
    .free_req_rdy       (free_req_rdy),
`ifdef TCP_FLOW_TABLE_STATS_EN
    .stat_lookup_miss_cnt (stat_lookup_miss_cnt),
    .stat_alloc_fail_cnt  (stat_alloc_fail_cnt),
    .stat_bad_free_cnt    (stat_bad_free_cnt),
`endif
    .init_done          (init_done),
    .flow_cnt           (flow_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a set of (id -> tag) bindings plus a FIFO of released ids.
  bit          m_valid [MF];
  logic [95:0] m_tag   [MF];
  int          m_free  [$];
  int          ms_miss, ms_fail, ms_bad;
  logic [95:0] tags    [5];

  function automatic logic [95:0] rand_tag();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void m_reset();
    m_free.delete();
    for (int i = 0; i < MF; i++) begin
      m_valid[i] = 1'b0;
      m_free.push_back(i);
    end
    ms_miss = 0;
    ms_fail = 0;
    ms_bad  = 0;
  endfunction

  function automatic void m_find(input logic [95:0] t, output bit hit, output int id);
    hit = 1'b0;
    id  = 0;
    for (int i = 0; i < MF; i++) begin
      if (m_valid[i] && m_tag[i] == t) begin
        hit = 1'b1;
        id  = i;
      end
    end
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < MF; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  function automatic void m_lookup(input logic [95:0] t, output bit hit, output int id);
    m_find(t, hit, id);
    if (!hit) ms_miss++;
  endfunction

  function automatic void m_alloc(input logic [95:0] t, output bit ok, output bit dup,
                                  output int id);
    m_find(t, dup, id);
    ok = 1'b0;
    if (!dup) begin
      if (m_free.size() > 0) begin
        id = m_free.pop_front();
        m_valid[id] = 1'b1;
        m_tag[id]   = t;
        ok = 1'b1;
      end else begin
        id = 0;
      end
    end
    if (!ok) ms_fail++;
  endfunction

  function automatic void m_free_id(input int id);
    if (m_valid[id]) begin
      m_valid[id] = 1'b0;
      m_free.push_back(id);
    end else begin
      ms_bad++;
    end
  endfunction

  // Bus drivers: called and return at posedge+1 with the FSM back in IDLE.
  task automatic do_alloc(input logic [95:0] t, output logic ok, output logic dup,
                          output logic [1:0] id, output bit to);
    int n = 0;
    to = 1'b0;
    alloc_req_tag = t;
    alloc_req_val = 1'b1;
    #1;
    while (!alloc_req_rdy && !to) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) to = 1'b1;
    end
    @(posedge clk); #1;
    alloc_req_val = 1'b0;
    if (!alloc_resp_val) to = 1'b1;
    ok  = alloc_resp_ok;
    dup = alloc_resp_dup;
    id  = alloc_resp_flowid;
    @(posedge clk); #1;
  endtask

  task automatic do_lookup(input logic [95:0] t, output logic hit, output logic [1:0] id,
                           output bit to);
    int n = 0;
    to = 1'b0;
    lookup_req_tag = t;
    lookup_req_val = 1'b1;
    #1;
    while (!lookup_req_rdy && !to) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) to = 1'b1;
    end
    @(posedge clk); #1;
    lookup_req_val = 1'b0;
    if (!lookup_resp_val) to = 1'b1;
    hit = lookup_resp_hit;
    id  = lookup_resp_flowid;
    @(posedge clk); #1;
  endtask

  task automatic do_free(input int id);
    free_req_flowid = 2'(id);
    free_req_val    = 1'b1;
    @(posedge clk); #1;
    free_req_val = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({lookup_resp_val, alloc_resp_val, init_done, free_req_rdy, flow_cnt} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {lookup_resp_val, alloc_resp_val,
               init_done, free_req_rdy, flow_cnt});
    end
    rst = 1'b0;
    while (!init_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL init_latency: got %0d cycles required 4", n);
    end
    n_cmp++;
    if (flow_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL init_flow_cnt: got %0d required 0", flow_cnt);
    end
  endtask

  task automatic test_fill();
    logic ok, dup;
    logic [1:0] id;
    bit to, eok, edup;
    int eid;
    for (int i = 0; i < 5; i++) begin
      tags[i] = rand_tag();
      m_alloc(tags[i], eok, edup, eid);
      do_alloc(tags[i], ok, dup, id, to);
      n_cmp++;
      if (to || ok !== eok || dup !== edup || id !== 2'(eid)) begin
        n_fail++;
        $display("FAIL fill_alloc%0d: got to=%0d ok=%b dup=%b id=%0d required ok=%b dup=%b id=%0d",
                 i, to, ok, dup, id, eok, edup, eid);
      end
    end
    n_cmp++;
    if (flow_cnt !== 3'(m_count())) begin
      n_fail++;
      $display("FAIL fill_flow_cnt: got %0d required %0d", flow_cnt, m_count());
    end
  endtask

  task automatic test_dup_lookup();
    logic ok, dup, hit;
    logic [1:0] id;
    bit to, eok, edup, ehit;
    int eid;
    m_alloc(tags[0], eok, edup, eid);
    do_alloc(tags[0], ok, dup, id, to);
    n_cmp++;
    if (to || ok !== eok || dup !== edup || id !== 2'(eid)) begin
      n_fail++;
      $display("FAIL dup_alloc: got ok=%b dup=%b id=%0d required ok=%b dup=%b id=%0d",
               ok, dup, id, eok, edup, eid);
    end
    for (int i = 0; i < 5; i++) begin
      m_lookup(tags[i], ehit, eid);
      do_lookup(tags[i], hit, id, to);
      n_cmp++;
      if (to || hit !== ehit || id !== 2'(eid)) begin
        n_fail++;
        $display("FAIL lookup%0d: got to=%0d hit=%b id=%0d required hit=%b id=%0d",
                 i, to, hit, id, ehit, eid);
      end
    end
  endtask

  task automatic test_free_realloc();
    logic ok, dup;
    logic [1:0] id;
    bit to, eok, edup;
    int eid;
    m_free_id(1);
    do_free(1);
    n_cmp++;
    if (flow_cnt !== 3'(m_count())) begin
      n_fail++;
      $display("FAIL free_flow_cnt: got %0d required %0d", flow_cnt, m_count());
    end
    m_free_id(1);
    do_free(1);
    n_cmp++;
    if (flow_cnt !== 3'(m_count())) begin
      n_fail++;
      $display("FAIL double_free_flow_cnt: got %0d required %0d", flow_cnt, m_count());
    end
`ifdef TCP_FLOW_TABLE_STATS_EN
    n_cmp++;
    if (stat_bad_free_cnt !== 32'(ms_bad)) begin
      n_fail++;
      $display("FAIL bad_free_stat: got %0d required %0d", stat_bad_free_cnt, ms_bad);
    end
`endif
    m_alloc(tags[4], eok, edup, eid);
    do_alloc(tags[4], ok, dup, id, to);
    n_cmp++;
    if (to || ok !== eok || dup !== edup || id !== 2'(eid)) begin
      n_fail++;
      $display("FAIL realloc: got ok=%b dup=%b id=%0d required ok=%b dup=%b id=%0d",
               ok, dup, id, eok, edup, eid);
    end
    n_cmp++;
    if (flow_cnt !== 3'(m_count())) begin
      n_fail++;
      $display("FAIL realloc_flow_cnt: got %0d required %0d", flow_cnt, m_count());
    end
  endtask

  task automatic test_priority();
    int fid, eid;
    bit eok, edup, ehit;
    logic [95:0] tf;
    fid = int'($urandom_range(0, MF - 1));
    tf  = rand_tag();
    lookup_resp_rdy = 1'b0;
    free_req_flowid = 2'(fid);
    free_req_val    = 1'b1;
    alloc_req_tag   = tf;
    alloc_req_val   = 1'b1;
    lookup_req_tag  = tf;
    lookup_req_val  = 1'b1;
    #1;
    n_cmp++;
    if ({free_req_rdy, alloc_req_rdy, lookup_req_rdy} !== 3'b100) begin
      n_fail++;
      $display("FAIL prio_free_first: got %b required 100",
               {free_req_rdy, alloc_req_rdy, lookup_req_rdy});
    end
    @(posedge clk); #1;
    free_req_val = 1'b0;
    m_free_id(fid);
    #1;
    n_cmp++;
    if ({free_req_rdy, alloc_req_rdy, lookup_req_rdy} !== 3'b010) begin
      n_fail++;
      $display("FAIL prio_alloc_second: got %b required 010",
               {free_req_rdy, alloc_req_rdy, lookup_req_rdy});
    end
    @(posedge clk); #1;
    alloc_req_val = 1'b0;
    m_alloc(tf, eok, edup, eid);
    n_cmp++;
    if (alloc_resp_val !== 1'b1 || alloc_resp_ok !== eok || alloc_resp_dup !== edup ||
        alloc_resp_flowid !== 2'(eid) || lookup_req_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_alloc_resp: got val=%b ok=%b dup=%b id=%0d lrdy=%b required 1 %b %b %0d 0",
               alloc_resp_val, alloc_resp_ok, alloc_resp_dup, alloc_resp_flowid,
               lookup_req_rdy, eok, edup, eid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (lookup_req_rdy !== 1'b1 || alloc_resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_lookup_third: got lrdy=%b aval=%b required 1 0",
               lookup_req_rdy, alloc_resp_val);
    end
    @(posedge clk); #1;
    lookup_req_val = 1'b0;
    m_lookup(tf, ehit, eid);
    alloc_req_tag = rand_tag();
    alloc_req_val = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (lookup_resp_val !== 1'b1 || lookup_resp_hit !== ehit ||
          lookup_resp_flowid !== 2'(eid) || alloc_req_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got val=%b hit=%b id=%0d ardy=%b required 1 %b %0d 0",
                 k, lookup_resp_val, lookup_resp_hit, lookup_resp_flowid, alloc_req_rdy,
                 ehit, eid);
      end
      @(posedge clk); #1;
    end
    lookup_resp_rdy = 1'b1;
    alloc_req_val   = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (lookup_resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got val=%b required 0", lookup_resp_val);
    end
  endtask

  task automatic test_random();
    logic [95:0] pool [6];
    logic ok, dup, hit;
    logic [1:0] id;
    bit to, eok, edup, ehit;
    int eid, op, fid;
    for (int i = 0; i < 6; i++) pool[i] = (i < 3) ? tags[i] : rand_tag();
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        fid = int'($urandom_range(0, MF - 1));
        m_free_id(fid);
        do_free(fid);
        n_cmp++;
        if (flow_cnt !== 3'(m_count())) begin
          n_fail++;
          $display("FAIL rnd_free%0d: got cnt=%0d required %0d", n, flow_cnt, m_count());
        end
      end else if (op == 1) begin
        eid = int'($urandom_range(0, 5));
        do_alloc(pool[eid], ok, dup, id, to);
        m_alloc(pool[eid], eok, edup, eid);
        n_cmp++;
        if (to || ok !== eok || dup !== edup || id !== 2'(eid) ||
            flow_cnt !== 3'(m_count())) begin
          n_fail++;
          $display("FAIL rnd_alloc%0d: got ok=%b dup=%b id=%0d cnt=%0d required %b %b %0d %0d",
                   n, ok, dup, id, flow_cnt, eok, edup, eid, m_count());
        end
      end else begin
        eid = int'($urandom_range(0, 5));
        do_lookup(pool[eid], hit, id, to);
        m_lookup(pool[eid], ehit, eid);
        n_cmp++;
        if (to || hit !== ehit || id !== 2'(eid)) begin
          n_fail++;
          $display("FAIL rnd_lookup%0d: got hit=%b id=%0d required hit=%b id=%0d",
                   n, hit, id, ehit, eid);
        end
      end
    end
  endtask

  task automatic test_stats();
`ifdef TCP_FLOW_TABLE_STATS_EN
    n_cmp++;
    if (stat_lookup_miss_cnt !== 32'(ms_miss) || stat_alloc_fail_cnt !== 32'(ms_fail) ||
        stat_bad_free_cnt !== 32'(ms_bad)) begin
      n_fail++;
      $display("FAIL stats: got %0d/%0d/%0d required %0d/%0d/%0d", stat_lookup_miss_cnt,
               stat_alloc_fail_cnt, stat_bad_free_cnt, ms_miss, ms_fail, ms_bad);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic ok, dup, hit;
    logic [1:0] id;
    bit to, eok, edup;
    int eid, fid, n;
    logic [95:0] ta;
    fid = int'($urandom_range(0, MF - 1));
    m_free_id(fid);
    do_free(fid);
    ta = rand_tag();
    m_alloc(ta, eok, edup, eid);
    do_alloc(ta, ok, dup, id, to);
    n_cmp++;
    if (to || ok !== 1'b1 || id !== 2'(eid)) begin
      n_fail++;
      $display("FAIL pre_reset_alloc: got ok=%b id=%0d required 1 %0d", ok, id, eid);
    end
    alloc_resp_rdy = 1'b0;
    alloc_req_tag  = rand_tag();
    alloc_req_val  = 1'b1;
    @(posedge clk); #1;
    alloc_req_val = 1'b0;
    n_cmp++;
    if (alloc_resp_val !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_resp_pending: got val=%b required 1", alloc_resp_val);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (alloc_resp_val !== 1'b0 || init_done !== 1'b0 || flow_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got val=%b init=%b cnt=%0d required 0 0 0",
               alloc_resp_val, init_done, flow_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    alloc_resp_rdy = 1'b1;
    m_reset();
    n = 0;
    while (!init_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL reinit_latency: got %0d cycles required 4", n);
    end
    do_lookup(ta, hit, id, to);
    n_cmp++;
    if (to || hit !== 1'b0 || id !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_lookup: got to=%0d hit=%b id=%0d required hit=0 id=0",
               to, hit, id);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_dup_lookup();
    test_free_realloc();
    test_priority();
    test_random();
    test_stats();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
